// File: rtl/configuration_irq_pkg.sv
// Shared constants for the configuration interrupt controller:
// register word addresses, vector register layout and source limit.
package configuration_irq_pkg;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;
  localparam logic [2:0] ADDR_SET     = 3'd6;

  localparam int VEC_VALID_BIT = 15;
  localparam int MAX_SRC       = 15;

endpackage

// File: rtl/configuration_irq_ctrl_if.sv
// Avalon-MM slave bus used by the processor to reach the interrupt
// controller: 3-bit word address, 16-bit data, registered readdata.
interface configuration_irq_ctrl_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/configuration_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active interrupt sources.
module configuration_irq_prio_enc #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [3:0]         index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    index = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/configuration_irq_ctrl.sv
// Interrupt aggregator: latches per-source irq lines as pending (edge or
// level mode), masks them and drives a single registered irq_out. Registers
// are held 16 bits wide; bits at and above NUM_SRC are forced to zero.
module configuration_irq_ctrl
  import configuration_irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  configuration_irq_ctrl_if.slave bus,
  input  logic [NUM_SRC-1:0]     irq_in,
  output logic                   irq_out
);

  localparam logic [15:0] SRC_BITS = 16'((32'd1 << NUM_SRC) - 32'd1);

  logic [15:0] pending;
  logic [15:0] mask;
  logic [15:0] mode;
  logic [15:0] irq_prev;

  logic [15:0] irq_in_ext;
  logic        wr_en;
  logic [15:0] w1c;
  logic [15:0] set_bits;
  logic [15:0] rise;
  logic [15:0] pending_next;
  logic [15:0] active;
  logic [15:0] vector;
  logic [15:0] read_mux;
  logic        vec_valid;
  logic [3:0]  vec_idx;

  assign irq_in_ext = 16'(irq_in);
  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign active     = pending & mask;
  assign rise       = irq_in_ext & ~irq_prev;

  configuration_irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (active[NUM_SRC-1:0]),
    .valid (vec_valid),
    .index (vec_idx)
  );

  // Edge bits: clear by W1C, then set by a rising edge or SET so that set
  // wins over a same-cycle clear. Level bits simply follow the input.
  always_comb begin
    w1c      = '0;
    set_bits = '0;
    if (wr_en && bus.address == ADDR_PENDING) w1c      = bus.writedata & SRC_BITS;
    if (wr_en && bus.address == ADDR_SET)     set_bits = bus.writedata & SRC_BITS;
    pending_next = ((mode & (((pending & ~w1c) | rise | set_bits))) |
                    (~mode & irq_in_ext)) & SRC_BITS;
  end

  // Read mux and vector layout, evaluated from register state before the edge.
  always_comb begin
    vector                = '0;
    vector[VEC_VALID_BIT] = vec_valid;
    vector[3:0]           = vec_idx;
    unique case (bus.address)
      ADDR_PENDING: read_mux = pending;
      ADDR_MASK:    read_mux = mask;
      ADDR_MODE:    read_mux = mode;
      ADDR_ACTIVE:  read_mux = active;
      ADDR_VECTOR:  read_mux = vector;
      ADDR_RAW:     read_mux = irq_in_ext;
      default:      read_mux = '0;
    endcase
  end

  // Register state, edge history, registered readdata and irq_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      mask         <= '0;
      mode         <= SRC_BITS;
      irq_prev     <= '0;
      bus.readdata <= '0;
      irq_out      <= 1'b0;
    end else begin
      pending      <= pending_next;
      irq_prev     <= irq_in_ext;
      bus.readdata <= read_mux;
      irq_out      <= |active;
      if (wr_en && bus.address == ADDR_MASK) mask <= bus.writedata & SRC_BITS;
      if (wr_en && bus.address == ADDR_MODE) mode <= bus.writedata & SRC_BITS;
    end
  end

endmodule

// File: tb/tb_configuration_irq_ctrl.sv
// Self-checking bench for configuration_irq_ctrl: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_configuration_irq_ctrl;

  localparam int          NUM_SRC = 4;
  localparam logic [15:0] VALID   = 16'h000F;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] irq_in;
  logic               irq_out;

  int checks = 0;
  int errors = 0;

  configuration_irq_ctrl_if bus ();

  configuration_irq_ctrl #(
    .NUM_SRC (NUM_SRC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  // Behavioural model state (values as they stand after the last edge)
  logic [15:0] m_pend = '0;
  logic [15:0] m_mask = '0;
  logic [15:0] m_mode = '0;
  logic [15:0] m_prev = '0;
  logic [15:0] m_rd   = '0;
  logic        m_irq  = 1'b0;

  function automatic logic [15:0] vec_of(input logic [15:0] act);
    for (int i = 0; i < 16; i++)
      if (act[i]) return 16'h8000 | 16'(i);
    return 16'h0000;
  endfunction

  // Model: apply the register rules to the inputs present at each edge
  always @(posedge clk) begin
    logic        wr;
    logic [15:0] nxt;
    logic [15:0] raw;
    raw = 16'(irq_in);
    if (reset) begin
      m_pend = '0; m_mask = '0; m_mode = VALID; m_prev = '0; m_rd = '0; m_irq = 1'b0;
    end else begin
      wr = bus.chipselect && !bus.write_n;
      case (bus.address)
        3'd0:    m_rd = m_pend;
        3'd1:    m_rd = m_mask;
        3'd2:    m_rd = m_mode;
        3'd3:    m_rd = m_pend & m_mask;
        3'd4:    m_rd = vec_of(m_pend & m_mask);
        3'd5:    m_rd = raw;
        default: m_rd = 16'h0000;
      endcase
      m_irq = (m_pend & m_mask) != 16'h0000;
      nxt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (m_mode[i]) begin
          nxt[i] = m_pend[i];
          if (wr && bus.address == 3'd0 && bus.writedata[i]) nxt[i] = 1'b0;
          if (raw[i] && !m_prev[i]) nxt[i] = 1'b1;
          if (wr && bus.address == 3'd6 && bus.writedata[i]) nxt[i] = 1'b1;
        end else begin
          nxt[i] = raw[i];
        end
      end
      if (wr && bus.address == 3'd1) m_mask = bus.writedata & VALID;
      if (wr && bus.address == 3'd2) m_mode = bus.writedata & VALID;
      m_pend = nxt;
      m_prev = raw;
    end
  end

  task automatic checkLiteral(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model
  task automatic checkOutput();
    checks++;
    if (bus.readdata !== m_rd || irq_out !== m_irq) begin
      errors++;
      $display("[TB] FAIL model t=%0t: readdata=0x%04h irq_out=%b, expected readdata=0x%04h irq_out=%b",
               $time, bus.readdata, irq_out, m_rd, m_irq);
    end
  endtask

  // Drive one cycle of inputs, cross the edge, sample at the falling edge
  task automatic applyStimulus(input logic rst, input logic [2:0] a, input logic cs,
                               input logic wn, input logic [15:0] wd,
                               input logic [NUM_SRC-1:0] irq);
    reset          = rst;
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    irq_in         = irq;
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic rd(input logic [2:0] a, input logic [NUM_SRC-1:0] irq);
    applyStimulus(1'b0, a, 1'b1, 1'b1, 16'h0000, irq);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] wd, input logic [NUM_SRC-1:0] irq);
    applyStimulus(1'b0, a, 1'b1, 1'b0, wd, irq);
  endtask

  logic [15:0] rst_exp [8];

  initial begin
    reset = 1'b1; bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.writedata = '0; irq_in = '0;
    @(negedge clk);

    // Reset state and full register map readback
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 16'h0000, 4'h0);
    checkLiteral("reset_irq_out", 16'(irq_out), 16'h0000);
    rst_exp = '{16'h0000, 16'h0000, 16'h000F, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 4'h0);
      checkLiteral($sformatf("reset_read_%0d", a), bus.readdata, rst_exp[a]);
    end

    // Single-cycle pulse on source 0, vector, then W1C
    wr(3'd1, 16'h0001, 4'h0);
    rd(3'd0, 4'h1);
    rd(3'd0, 4'h0);
    checkLiteral("pulse_pending", bus.readdata, 16'h0001);
    checkLiteral("pulse_irq_out", 16'(irq_out), 16'h0001);
    rd(3'd4, 4'h0);
    checkLiteral("pulse_vector", bus.readdata, 16'h8000);
    wr(3'd0, 16'h0001, 4'h0);
    rd(3'd0, 4'h0);
    checkLiteral("w1c_irq_out", 16'(irq_out), 16'h0000);
    checkLiteral("w1c_pending", bus.readdata, 16'h0000);

    // Rise on source 2 coincident with its W1C: set wins; held high sets once
    wr(3'd0, 16'h0004, 4'h4);
    rd(3'd0, 4'h4);
    checkLiteral("rise_beats_w1c", bus.readdata, 16'h0004);
    for (int i = 0; i < 4; i++) rd(3'd0, 4'h4);
    wr(3'd0, 16'h0004, 4'h4);
    for (int i = 0; i < 4; i++) rd(3'd0, 4'h4);
    checkLiteral("held_high_no_reset", bus.readdata, 16'h0000);
    rd(3'd0, 4'h0);

    // Level mode: follows input, ignores W1C
    wr(3'd2, 16'h0000, 4'h0);
    wr(3'd1, 16'h000F, 4'h0);
    rd(3'd0, 4'h6);
    rd(3'd4, 4'h6);
    checkLiteral("level_vector", bus.readdata, 16'h8001);
    rd(3'd0, 4'h6);
    checkLiteral("level_pending", bus.readdata, 16'h0006);
    wr(3'd0, 16'h0006, 4'h6);
    rd(3'd0, 4'h6);
    checkLiteral("level_w1c_ignored", bus.readdata, 16'h0006);
    rd(3'd0, 4'h0);
    rd(3'd0, 4'h0);
    checkLiteral("level_drop_pending", bus.readdata, 16'h0000);
    checkLiteral("level_drop_irq_out", 16'(irq_out), 16'h0000);

    // SET with mask off, then unmask; reserved address
    wr(3'd2, 16'h000F, 4'h0);
    wr(3'd1, 16'h0000, 4'h0);
    wr(3'd6, 16'h0008, 4'h0);
    rd(3'd0, 4'h0);
    checkLiteral("set_pending", bus.readdata, 16'h0008);
    checkLiteral("set_masked_irq", 16'(irq_out), 16'h0000);
    wr(3'd1, 16'h0008, 4'h0);
    rd(3'd6, 4'h0);
    checkLiteral("unmask_irq_out", 16'(irq_out), 16'h0001);
    checkLiteral("set_reads_zero", bus.readdata, 16'h0000);
    wr(3'd7, 16'hFFFF, 4'h0);
    rd(3'd7, 4'h0);
    checkLiteral("reserved_reads_zero", bus.readdata, 16'h0000);

    // Reset while everything pending and irq_out high
    wr(3'd6, 16'h000F, 4'h0);
    wr(3'd1, 16'h000F, 4'h0);
    rd(3'd0, 4'h0);
    checkLiteral("pre_reset_pending", bus.readdata, 16'h000F);
    checkLiteral("pre_reset_irq", 16'(irq_out), 16'h0001);
    applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 16'h0000, 4'h0);
    checkLiteral("mid_reset_irq", 16'(irq_out), 16'h0000);
    checkLiteral("mid_reset_rd", bus.readdata, 16'h0000);
    rd(3'd2, 4'h0);
    checkLiteral("post_reset_mode", bus.readdata, 16'h000F);
    rd(3'd0, 4'h0);
    checkLiteral("post_reset_pending", bus.readdata, 16'h0000);

    // Randomized traffic checked every cycle against the model
    begin
      logic [NUM_SRC-1:0] irq_r;
      irq_r = '0;
      for (int n = 0; n < 3000; n++) begin
        logic [2:0]  a;
        logic [15:0] wd;
        if ($urandom_range(3) == 0) irq_r = NUM_SRC'($urandom);
        a  = 3'($urandom);
        wd = 16'($urandom);
        if (a == 3'd2 && $urandom_range(1) == 0) wd = 16'hFFFF;
        applyStimulus(($urandom_range(127) == 0), a, 1'($urandom_range(3) != 0),
                      1'($urandom_range(2) != 0), wd, irq_r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
